// File: rtl/sram_16x16.sv
// Single-port, write-first synchronous SRAM. The registered read port and every storage word are cleared asynchronously by rst.
// Define SRAM_PARITY_EN to add a parity bit to each word and a parity_err output.
module sram_16x16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef SRAM_PARITY_EN
  output logic              parity_err,
`endif
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    mem_d = mem_q;
    rdata_d = mem_q[addr];
    if (we) begin
      mem_d[addr] = wdata;
      rdata_d = wdata;
    end
  end

  // The memory lives in resettable flops, so rst clears every word immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      rdata_q <= '0;
    end else begin
      mem_q <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

`ifdef SRAM_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic [DEPTH-1:0] par_d;
  logic             parity_err_q;
  logic             parity_err_d;

  always_comb begin
    par_d = par_q;
    parity_err_d = (^mem_q[addr]) ^ par_q[addr];
    if (we) begin
      par_d[addr] = ^wdata;
      parity_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= '0;
      parity_err_q <= 1'b0;
    end else begin
      par_q <= par_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sram_16x16.sv
// Randomized self-checking bench for sram_16x16 against an array-based memory model.
module tb_sram_16x16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
`ifdef SRAM_PARITY_EN
  logic        parity_err;
`endif

  int n_checks = 0;
  int n_pass = 0;

  logic [15:0] model [16];
  logic [15:0] exp_rd = '0;

  sram_16x16 #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .we(we),
    .addr(addr),
    .wdata(wdata),
`ifdef SRAM_PARITY_EN
    .parity_err(parity_err),
`endif
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One access: inputs applied away from the edge, result sampled 1 time unit after the edge.
  task automatic access(input logic w, input logic [3:0] a, input logic [15:0] d,
                        input string tag, input bit do_check);
    we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (w) begin
        model[a] = d;
        exp_rd = d;
      end else begin
        exp_rd = model[a];
      end
    end
    if (do_check) check(tag, {16'h0, rdata}, {16'h0, exp_rd});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    exp_rd = '0;
    check("reset_rdata_async", {16'h0, rdata}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] vals [4];
    logic [15:0] held;
    vals[0] = 16'hAAAA; vals[1] = 16'h5678; vals[2] = 16'hB4B3; vals[3] = 16'hCCCC;
    for (int i = 0; i < 16; i++) model[i] = '0;

    @(negedge clk);
    do_reset();

    access(1'b0, 4'd1, 16'h0, "rst_read_a1", 1'b1);
    access(1'b0, 4'd5, 16'h0, "rst_read_a5", 1'b1);

    for (int i = 0; i < 4; i++) access(1'b1, 4'(2 * i), vals[i], "b2b_write", 1'b0);
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 4'(2 * i), 16'h0, "b2b_read", 1'b0);
      check("b2b_read_val", {16'h0, rdata}, {16'h0, vals[i]});
    end

    access(1'b1, 4'd3, 16'h1234, "write_first", 1'b0);
    check("write_first_val", {16'h0, rdata}, 32'h1234);
    access(1'b1, 4'd3, 16'hFFFF, "same_addr_w", 1'b1);
    access(1'b0, 4'd3, 16'h0, "same_addr_r", 1'b0);
    check("same_addr_last", {16'h0, rdata}, 32'hFFFF);

    for (int i = 0; i < 16; i++) access(1'b1, 4'(i), 16'(i * 16'h1111), "fill_w", 1'b1);
    for (int i = 0; i < 16; i++) begin
      access(1'b0, 4'(i), 16'h0, "fill_r", 1'b0);
      check("fill_r_val", {16'h0, rdata}, {16'h0, 16'(i * 16'h1111)});
    end

    // rdata must ignore input changes between edges
    held = rdata;
    addr = 4'd0; wdata = 16'h9999; we = 1'b1;
    #2;
    check("hold_between_edges", {16'h0, rdata}, {16'h0, held});

    // Reset mid-operation with a pending write
    we = 1'b1; addr = 4'd6; wdata = 16'hCCCC;
    @(posedge clk);
    #2;
    model[6] = 16'hCCCC;
    we = 1'b1; addr = 4'd7; wdata = 16'h7777;
    rst = 1'b1;
    #1;
    check("rst_mid_rdata", {16'h0, rdata}, 32'h0);
    for (int i = 0; i < 16; i++) model[i] = '0;
    exp_rd = '0;
    @(negedge clk);
    access(1'b1, 4'd8, 16'h8888, "rst_ignores_write", 1'b1);
    rst = 1'b0;
    access(1'b0, 4'd6, 16'h0, "post_rst_a6", 1'b1);
    access(1'b0, 4'd7, 16'h0, "post_rst_a7", 1'b1);
    access(1'b0, 4'd8, 16'h0, "post_rst_a8", 1'b1);

`ifdef SRAM_PARITY_EN
    access(1'b1, 4'd9, 16'h0001, "par_w", 1'b1);
    check("par_err_write", {31'h0, parity_err}, 32'h0);
    access(1'b0, 4'd9, 16'h0, "par_r", 1'b1);
    check("par_err_clean", {31'h0, parity_err}, 32'h0);
    dut.mem_q[9] = 16'h0003;
    model[9] = 16'h0003;
    access(1'b0, 4'd9, 16'h0, "par_r_flip", 1'b1);
    check("par_err_flip", {31'h0, parity_err}, 32'h1);
    access(1'b1, 4'd9, 16'h0001, "par_rewrite", 1'b1);
`endif

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
             "random", 1'b1);
`ifdef SRAM_PARITY_EN
      check("random_par", {31'h0, parity_err}, 32'h0);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sram_16x16.md
SRAM_16X16 -- requirements
Module: sram_16x16

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words (16 by default).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 we  input  1  write enable; 1 = write cycle, 0 = read cycle.
REQ-006 addr  input  ADDR_W  word address for read or write.
REQ-007 wdata  input  DATA_W  write data.
REQ-008 rdata  output  DATA_W  registered read data.
REQ-009 parity_err  output  1  parity mismatch flag; present only when SRAM_PARITY_EN is defined.

Function
REQ-010 Storage SHALL be DEPTH words of DATA_W bits, single port, one access per cycle.
REQ-011 On a rising clk edge with we=1, mem[addr] SHALL take wdata.
REQ-012 On a rising clk edge with we=0, rdata SHALL take mem[addr]; read latency is one clock edge.
REQ-013 On a write edge, rdata SHALL take wdata (write-first): the new data is visible one edge later, and the old contents are not returned.
REQ-014 rdata SHALL hold its last value between edges and SHALL be unaffected by addr/wdata changes until the next edge.
REQ-015 All addresses 0..DEPTH-1 SHALL be valid; there is no out-of-range condition and no wrap logic.
REQ-016 Back-to-back writes to different addresses on consecutive edges SHALL all complete, with no stall or handshake.
REQ-017 Writing the same address on consecutive edges SHALL leave the last value written.
REQ-018 Every word that has not been written since reset SHALL read as 0.

Reset
REQ-019 rst=1 SHALL immediately, without waiting for clk, clear rdata to 0 and all DEPTH words to 0.
REQ-020 While rst=1, writes and reads SHALL be ignored and rdata SHALL stay 0.
REQ-021 When rst is asserted mid-operation, any pending write SHALL be discarded.
REQ-022 The first edge after rst deasserts SHALL perform a normal access.

Configuration
REQ-023 Macro SRAM_PARITY_EN SHALL compile in per-word parity.
REQ-024 With SRAM_PARITY_EN defined:
- each word stores one extra bit, the XOR of wdata;
- on each read edge, parity_err SHALL register the XOR of the stored data and the stored parity bit;
- on write edges, parity_err SHALL register 0;
- reset SHALL clear all parity bits and parity_err to 0.
REQ-025 Without SRAM_PARITY_EN, there SHALL be no parity storage, no parity_err port, and behaviour SHALL be identical in all other respects.

Verification
REQ-026 Reset then read addr 1 and addr 5 -> rdata=16'h0000 each.
REQ-027 Write 0:16'hAAAA, 2:16'h5678, 4:16'hB4B3, 6:16'hCCCC on consecutive edges, then read 0, 2, 4, 6 -> rdata equals the matching value one edge after each address is applied.
REQ-028 Write addr 3 with 16'h1234 -> rdata=16'h1234 after that same edge; write 16'hFFFF to addr 3 then read addr 3 -> 16'hFFFF.
REQ-029 Fill addr 0..15 with value = addr*16'h1111, then read all -> each matches, and addr 15 returns 16'hFFFF.
REQ-030 Write addr 6=16'hCCCC, assert rst between edges -> rdata is 0 immediately; after release, read addr 6 -> 16'h0000.
REQ-031 With SRAM_PARITY_EN defined, write 16'h0001 and read it back -> parity_err=0; force a stored data bit flip through the bench backdoor and read -> parity_err=1.
